// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared constants for the Y86-64 execute-stage ALU.
//   WORD_W   : machine word width in bits
//   ALU_ADD  : operation code for num1 + num2
//   ALU_SUB  : operation code for num1 - num2 (valB - valA ordering)
//   ALU_AND  : operation code for bitwise AND
//   ALU_XOR  : operation code for bitwise XOR
// ---------------------------------------------------------------------------
package y86_pkg;

    localparam int WORD_W = 64;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

endpackage

// File: rtl/y86_adder64.sv
// ---------------------------------------------------------------------------
// y86_adder64
// Word-wide adder built from 4-bit carry-lookahead groups. Inside a group
// every carry is computed directly from the group inputs; between groups
// the carry ripples.
// Ports:
//   a    in  WIDTH  addend
//   b    in  WIDTH  addend (already inverted by the caller for subtraction)
//   cin  in  1      carry into bit 0 (1 for subtraction)
//   sum  out WIDTH  a + b + cin, truncated to WIDTH bits
//   cout out 1      carry out of the top bit
// ---------------------------------------------------------------------------
module y86_adder64
    import y86_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int GROUPS = WIDTH / 4;

    // group_carry[g] is the carry entering group g
    logic [GROUPS:0] group_carry;

    assign group_carry[0] = cin;

    for (genvar g = 0; g < GROUPS; g++) begin : g_cla
        logic [3:0] p;
        logic [3:0] gen;
        logic [4:0] c;

        assign p   = a[4*g +: 4] ^ b[4*g +: 4];
        assign gen = a[4*g +: 4] & b[4*g +: 4];

        // Fully expanded lookahead equations for the four carries of the group
        assign c[0] = group_carry[g];
        assign c[1] = gen[0] | (p[0] & c[0]);
        assign c[2] = gen[1] | (p[1] & gen[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = gen[2] | (p[2] & gen[1]) | (p[2] & p[1] & gen[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = gen[3] | (p[3] & gen[2]) | (p[3] & p[2] & gen[1])
                    | (p[3] & p[2] & p[1] & gen[0])
                    | (p[3] & p[2] & p[1] & p[0] & c[0]);

        assign sum[4*g +: 4]    = p ^ c[3:0];
        assign group_carry[g+1] = c[4];
    end

    assign cout = group_carry[GROUPS];

endmodule

// File: rtl/y86_alu.sv
// ---------------------------------------------------------------------------
// y86_alu
// 64-bit integer ALU for the Y86-64 execute stage. Computes ADD, SUB, AND
// and XOR plus a signed-overflow flag; both outputs are registered, giving
// one cycle of latency with a new operation accepted every cycle.
// Ports:
//   clk           in  1      rising-edge clock
//   rst_n         in  1      synchronous active-low reset
//   num1          in  WIDTH  operand A (valB)
//   num2          in  WIDTH  operand B (valA, valC or +/-8)
//   operation     in  2      00=ADD 01=SUB 10=AND 11=XOR
//   result        out WIDTH  registered result
//   overflow_flag out 1      registered signed overflow for result
// ---------------------------------------------------------------------------
module y86_alu
    import y86_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [1:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             overflow_flag
);

    localparam int MSB = WIDTH - 1;

    logic             is_sub;
    logic [WIDTH-1:0] adder_b;
    logic [WIDTH-1:0] adder_sum;
    logic             unused_cout;
    logic [WIDTH-1:0] next_result;
    logic             next_overflow;

    // Subtraction reuses the adder as num1 + ~num2 + 1
    assign is_sub  = (operation == ALU_SUB);
    assign adder_b = is_sub ? ~num2 : num2;

    y86_adder64 #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a   (num1),
        .b   (adder_b),
        .cin (is_sub),
        .sum (adder_sum),
        .cout(unused_cout)
    );

    // Result select and signed-overflow detection. Overflow is only possible
    // when the effective operands share a sign and the result sign differs.
    always_comb begin
        next_result   = '0;
        next_overflow = 1'b0;
        case (operation)
            ALU_ADD: begin
                next_result   = adder_sum;
                next_overflow = (num1[MSB] == num2[MSB]) && (adder_sum[MSB] != num1[MSB]);
            end
            ALU_SUB: begin
                next_result   = adder_sum;
                next_overflow = (num1[MSB] != num2[MSB]) && (adder_sum[MSB] != num1[MSB]);
            end
            ALU_AND: begin
                next_result = num1 & num2;
            end
            ALU_XOR: begin
                next_result = num1 ^ num2;
            end
            default: begin
                next_result   = '0;
                next_overflow = 1'b0;
            end
        endcase
    end

    // Output registers; reset takes priority over the operation being sampled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result        <= '0;
            overflow_flag <= 1'b0;
        end else begin
            result        <= next_result;
            overflow_flag <= next_overflow;
        end
    end

endmodule

// File: tb/tb_y86_alu.sv
// ---------------------------------------------------------------------------
// tb_y86_alu
// Self-checking bench for y86_alu: reset behaviour, a table of directed
// vectors applied back-to-back, a mid-stream reset, and random vectors
// compared against a sign-extended arithmetic model.
// ---------------------------------------------------------------------------
module tb_y86_alu;
    import y86_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [63:0] num1;
    logic [63:0] num2;
    logic [1:0]  operation;
    logic [63:0] result;
    logic        overflow_flag;

    int checks;
    int failures;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_r;
        logic        exp_o;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    y86_alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .num1         (num1),
        .num2         (num2),
        .operation    (operation),
        .result       (result),
        .overflow_flag(overflow_flag)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation, let it be captured on the next rising edge, then
    // settle just past the edge so outputs can be sampled safely
    task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        operation = op;
        num1      = a;
        num2      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] exp_r, input logic exp_o);
        checks++;
        if (result !== exp_r || overflow_flag !== exp_o) begin
            failures++;
            $display("[TB] FAIL %s: got result=%h ovf=%b, expected result=%h ovf=%b",
                     tag, result, overflow_flag, exp_r, exp_o);
        end
    endtask

    // Reference computed with 65-bit sign-extended arithmetic: a signed
    // overflow shows up as bit 64 disagreeing with bit 63
    function automatic void model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic o);
        logic [64:0] ext;
        ext = '0;
        r   = '0;
        o   = 1'b0;
        case (op)
            ALU_ADD: begin
                ext = {a[63], a} + {b[63], b};
                r   = ext[63:0];
                o   = ext[64] ^ ext[63];
            end
            ALU_SUB: begin
                ext = {a[63], a} - {b[63], b};
                r   = ext[63:0];
                o   = ext[64] ^ ext[63];
            end
            ALU_AND: r = a & b;
            default: r = a ^ b;
        endcase
    endfunction

    initial begin
        logic [63:0] ra, rb, er;
        logic [1:0]  rop;
        logic        eo;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1};
        vecs[1]  = '{ALU_ADD, 64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 64'hF8, 1'b0};
        vecs[2]  = '{ALU_SUB, 64'd10, 64'd3, 64'd7, 1'b0};
        vecs[3]  = '{ALU_SUB, 64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0};
        vecs[4]  = '{ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[5]  = '{ALU_SUB, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1};
        vecs[6]  = '{ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};
        vecs[7]  = '{ALU_AND, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0};
        vecs[8]  = '{ALU_XOR, 64'hFFFF, 64'h0F0F, 64'hF0F0, 1'b0};
        vecs[9]  = '{ALU_AND, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0};
        vecs[10] = '{ALU_XOR, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[11] = '{ALU_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
        vecs[12] = '{ALU_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1};
        vecs[13] = '{ALU_ADD, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFF8, 1'b0};
        vecs[14] = '{ALU_ADD, 64'h0FFF_FFFF_FFFF_FFFF, 64'd1, 64'h1000_0000_0000_0000, 1'b0};

        // Reset held for two edges with a live ADD on the inputs
        rst_n = 1'b0;
        applyStimulus(ALU_ADD, 64'd5, 64'd3);
        checkOutput("reset_edge1", 64'd0, 1'b0);
        applyStimulus(ALU_ADD, 64'd5, 64'd3);
        checkOutput("reset_edge2", 64'd0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(ALU_ADD, 64'd5, 64'd3);
        checkOutput("first_after_reset", 64'd8, 1'b0);

        // Directed table, one vector per consecutive cycle
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_r, vecs[i].exp_o);
        end

        // Back-to-back stream with a reset asserted in the middle
        applyStimulus(ALU_ADD, 64'd20, 64'd22);
        checkOutput("stream_add", 64'd42, 1'b0);
        applyStimulus(ALU_SUB, 64'd20, 64'd22);
        checkOutput("stream_sub", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        rst_n = 1'b0;
        applyStimulus(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        checkOutput("stream_reset", 64'd0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(ALU_AND, 64'hAAAA, 64'h0FF0);
        checkOutput("stream_and", 64'h0AA0, 1'b0);
        applyStimulus(ALU_XOR, 64'hAAAA, 64'h0FF0);
        checkOutput("stream_xor", 64'hA55A, 1'b0);

        // Random vectors against the reference model
        for (int i = 0; i < 10000; i++) begin
            ra  = {$urandom(), $urandom()};
            rb  = {$urandom(), $urandom()};
            rop = 2'($urandom_range(0, 3));
            model(rop, ra, rb, er, eo);
            applyStimulus(rop, ra, rb);
            checkOutput($sformatf("rand%0d", i), er, eo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
